// File: rtl/des_key_sched_dec_if.sv
// Key-load and subkey-stream handshake bundle for the decrypt-order DES key schedule.
// The slave modport is the schedule block's view; master is the key source / subkey consumer.
interface des_key_sched_dec_if;
   logic [63:0] key_in;
   logic        key_load;
   logic        key_ready;
   logic [47:0] subkey;
   logic        subkey_valid;
   logic        subkey_ready;
   logic [4:0]  round_num;
   logic        last;

   modport master (
      output key_in, key_load, subkey_ready,
      input  key_ready, subkey, subkey_valid, round_num, last
   );

   modport slave (
      input  key_in, key_load, subkey_ready,
      output key_ready, subkey, subkey_valid, round_num, last
   );
endinterface

// File: rtl/des_key_sched_dec.sv
// DES key schedule producing subkeys K16..K1 for decryption, one per accepted handshake.
// C/D start at PC-1(key), which equals C16/D16, and rotate right to walk back toward C1/D1.
module des_key_sched_dec (
   input  logic                  clk,
   input  logic                  n_rst,
   des_key_sched_dec_if.slave    bus
);

   typedef enum logic {IDLE, RUN} state_t;

   // FIPS 46-3 bit numbers (1 = MSB); element 0 of each list sits at the top index.
   localparam logic [55:0][5:0] PC1_T = {
      6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
      6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
      6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
      6'd60, 6'd52, 6'd44, 6'd36, 6'd63, 6'd55, 6'd47, 6'd39,
      6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38,
      6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37,
      6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
   };

   localparam logic [47:0][5:0] PC2_T = {
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
      6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
      6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
      6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
      6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
   };

   state_t      state_q, state_d;
   logic [27:0] c_q, c_d, d_q, d_d;
   logic [4:0]  rnd_q, rnd_d;
   logic [55:0] pc1_cd;
   logic [55:0] cd_q;
   logic [47:0] pc2_k;
   logic        shift_two;

   assign cd_q = {c_q, d_q};

   for (genvar i = 0; i < 56; i++) begin : g_pc1
      assign pc1_cd[55-i] = bus.key_in[64-PC1_T[55-i]];
   end

   for (genvar i = 0; i < 48; i++) begin : g_pc2
      assign pc2_k[47-i] = cd_q[56-PC2_T[47-i]];
   end

   // Rounds 1, 2, 9 and 16 shift by one; all others by two.
   always_comb begin
      shift_two = 1'b1;
      if (rnd_q == 5'd1 || rnd_q == 5'd2 || rnd_q == 5'd9 || rnd_q == 5'd16)
         shift_two = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      rnd_d   = rnd_q;
      case (state_q)
         IDLE: begin
            if (bus.key_load) begin
               c_d     = pc1_cd[55:28];
               d_d     = pc1_cd[27:0];
               rnd_d   = 5'd16;
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.subkey_ready) begin
               if (rnd_q == 5'd1) begin
                  // Clearing C/D keeps subkey at zero while idle.
                  c_d     = '0;
                  d_d     = '0;
                  rnd_d   = '0;
                  state_d = IDLE;
               end else begin
                  rnd_d = rnd_q - 5'd1;
                  if (shift_two) begin
                     c_d = {c_q[1:0], c_q[27:2]};
                     d_d = {d_q[1:0], d_q[27:2]};
                  end else begin
                     c_d = {c_q[0], c_q[27:1]};
                     d_d = {d_q[0], d_q[27:1]};
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         c_q     <= '0;
         d_q     <= '0;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         d_q     <= d_d;
         rnd_q   <= rnd_d;
      end
   end

   assign bus.key_ready    = (state_q == IDLE);
   assign bus.subkey_valid = (state_q == RUN);
   assign bus.round_num    = rnd_q;
   assign bus.last         = (state_q == RUN) && (rnd_q == 5'd1);
   assign bus.subkey       = pc2_k;

endmodule

// File: tb/tb_des_key_sched_dec.sv
// Scoreboard bench for the decrypt-order DES key schedule: stimulus pushes expected
// (round, subkey) pairs, a negedge monitor checks every presented subkey against the queue head.
module tb_des_key_sched_dec;

   localparam logic [63:0] KEY_A   = 64'h133457799BBCDFF1;
   localparam logic [63:0] KEY_PAR = 64'h123556789ABDDEF0;

   localparam int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,
                               60,52,44,36,63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,
                               29,21,13,5,28,20,12,4};
   localparam int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                               41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
   localparam int SHIFTS [17] = '{0,1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   typedef struct packed {
      logic [4:0]  rnd;
      logic [47:0] key;
   } exp_t;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   des_key_sched_dec_if bus ();
   des_key_sched_dec dut (.clk(clk), .n_rst(n_rst), .bus(bus));

   exp_t        exp_q[$];
   logic [47:0] ka [1:16];
   int          checks   = 0;
   int          failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Independent encrypt-direction model: cumulative left shifts from C0/D0.
   function automatic logic [47:0] ref_subkey(input logic [63:0] k, input int rnd);
      logic [27:0] c, d;
      logic [55:0] cd;
      logic [47:0] r;
      for (int i = 0; i < 28; i++) begin
         c[27-i] = k[64-PC1[i]];
         d[27-i] = k[64-PC1[i+28]];
      end
      for (int j = 1; j <= rnd; j++)
         for (int s = 0; s < SHIFTS[j]; s++) begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
         end
      cd = {c, d};
      for (int i = 0; i < 48; i++) r[47-i] = cd[56-PC2[i]];
      return r;
   endfunction

   always @(negedge clk) begin
      if (n_rst && bus.subkey_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_subkey actual=%h round=%0d expected=none", bus.subkey, bus.round_num);
         end else begin
            chk("subkey", 64'(bus.subkey), 64'(exp_q[0].key));
            chk("round_num", 64'(bus.round_num), 64'(exp_q[0].rnd));
            chk("last", 64'(bus.last), 64'(exp_q[0].rnd == 5'd1));
            if (bus.subkey_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic push_ka();
      for (int r = 16; r >= 1; r--) exp_q.push_back({5'(r), ka[r]});
   endtask

   task automatic push_model(input logic [63:0] k);
      for (int r = 16; r >= 1; r--) exp_q.push_back({5'(r), ref_subkey(k, r)});
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic load(input logic [63:0] k);
      bus.key_in   = k;
      bus.key_load = 1'b1;
      tick(1);
      bus.key_load = 1'b0;
      bus.key_in   = ~k;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      while (!bus.key_ready && n < 40) begin
         tick(1);
         n++;
      end
      chk(name, 64'(bus.key_ready), 64'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      ka[16] = 48'hCB3D8B0E17F5; ka[15] = 48'hBF918D3D3F0A; ka[14] = 48'h5F43B7F2E73A;
      ka[13] = 48'h97C5D1FABA41; ka[12] = 48'h7571F59467E9; ka[11] = 48'h215FD3DED386;
      ka[10] = 48'hB1F347BA464F; ka[9]  = 48'hE0DBEBEDE781; ka[8]  = 48'hF78A3AC13BFB;
      ka[7]  = 48'hEC84B7F618BC; ka[6]  = 48'h63A53E507B2F; ka[5]  = 48'h7CEC07EB53A8;
      ka[4]  = 48'h72ADD6DB351D; ka[3]  = 48'h55FC8A42CF99; ka[2]  = 48'h79AED9DBC9E5;
      ka[1]  = 48'h1B02EFFC7072;

      bus.key_in = '0; bus.key_load = 1'b0; bus.subkey_ready = 1'b0;
      n_rst = 1'b0;
      #12;
      chk("rst_key_ready", 64'(bus.key_ready), 64'd1);
      chk("rst_valid", 64'(bus.subkey_valid), 64'd0);
      chk("rst_round", 64'(bus.round_num), 64'd0);
      chk("rst_subkey", 64'(bus.subkey), 64'd0);
      chk("rst_last", 64'(bus.last), 64'd0);
      tick(1);
      n_rst = 1'b1;
      tick(1);

      // Back-to-back pass with known vector, exact latency and return to idle.
      bus.subkey_ready = 1'b1;
      push_ka();
      load(KEY_A);
      chk("lat_valid", 64'(bus.subkey_valid), 64'd1);
      chk("lat_round", 64'(bus.round_num), 64'd16);
      chk("run_key_ready", 64'(bus.key_ready), 64'd0);
      tick(15);
      chk("round1_last", 64'(bus.last), 64'd1);
      tick(1);
      chk("done_key_ready", 64'(bus.key_ready), 64'd1);
      chk("done_valid", 64'(bus.subkey_valid), 64'd0);
      chk("done_subkey", 64'(bus.subkey), 64'd0);

      // Consumer stalls for five cycles on the first subkey.
      bus.subkey_ready = 1'b0;
      push_ka();
      load(KEY_A);
      tick(4);
      bus.subkey_ready = 1'b1;
      tick(1);
      chk("stall_next_round", 64'(bus.round_num), 64'd15);
      chk("stall_next_subkey", 64'(bus.subkey), 64'(48'hBF918D3D3F0A));
      wait_idle("stall_idle");

      // Parity bits must not matter.
      push_ka();
      load(KEY_PAR);
      wait_idle("parity_idle");

      // key_load during RUN is ignored.
      push_ka();
      load(KEY_A);
      tick(6);
      bus.key_in = 64'h0123456789ABCDEF;
      bus.key_load = 1'b1;
      tick(1);
      bus.key_load = 1'b0;
      wait_idle("ignore_idle");

      // key_load coincident with the final transfer does not start a pass.
      push_ka();
      load(KEY_A);
      tick(15);
      bus.key_in = KEY_A;
      bus.key_load = 1'b1;
      tick(1);
      bus.key_load = 1'b0;
      chk("coinc_key_ready", 64'(bus.key_ready), 64'd1);
      chk("coinc_valid", 64'(bus.subkey_valid), 64'd0);
      tick(1);
      chk("coinc_still_idle", 64'(bus.subkey_valid), 64'd0);

      // Reset mid-pass at round 8, then a fresh pass.
      push_ka();
      load(KEY_A);
      tick(8);
      chk("pre_rst_round", 64'(bus.round_num), 64'd8);
      n_rst = 1'b0;
      #1;
      exp_q.delete();
      chk("midrst_key_ready", 64'(bus.key_ready), 64'd1);
      chk("midrst_valid", 64'(bus.subkey_valid), 64'd0);
      chk("midrst_round", 64'(bus.round_num), 64'd0);
      chk("midrst_subkey", 64'(bus.subkey), 64'd0);
      chk("midrst_last", 64'(bus.last), 64'd0);
      tick(1);
      n_rst = 1'b1;
      tick(2);
      chk("postrst_wait", 64'(bus.subkey_valid), 64'd0);
      push_ka();
      load(KEY_A);
      chk("restart_round", 64'(bus.round_num), 64'd16);
      chk("restart_subkey", 64'(bus.subkey), 64'(48'hCB3D8B0E17F5));
      wait_idle("restart_idle");

      // Random keys against the encrypt-order model, reversed.
      for (int t = 0; t < 200; t++) begin
         logic [63:0] k;
         k = {$urandom, $urandom};
         push_model(k);
         load(k);
         wait_idle("rand_idle");
      end

      tick(2);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
